// File: rtl/data_memory_pkg.sv
// Shared types and constants for the MEM-stage data RAM.
package data_memory_pkg;

  localparam int DATA_W           = 16;
  localparam int ADDR_W           = 32;
  localparam int DEPTH_LOG2_DFLT  = 11;
  localparam logic [ADDR_W-1:0] STACK_TOP = 32'hFFFF_FFFF;

  typedef logic [DATA_W-1:0] word_t;

  // A push is just a store at SP, so both enables collapse into one write
  function automatic logic write_enable(input logic cs, input logic mem_write,
                                        input logic push);
    return cs & (mem_write | push);
  endfunction

  function automatic logic read_enable(input logic cs, input logic mem_read);
    return cs & mem_read;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed 16-bit data RAM: combinational read, synchronous write, async clear.
// Optional macro DMEM_COLLISION_EN adds the 'collision' output.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] dataOut,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              CS,
  input  logic              push
`ifdef DMEM_COLLISION_EN
  ,
  output logic              collision
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  word_t                 mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  wen_s;
  logic                  ren_s;
  logic                  unused_addr_bits;

  // Upper address bits are dropped on purpose: STACK_TOP lands on the top word
  // and SP+1 wraps to word 0 without any extra logic.
  assign idx_s            = address[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^address[ADDR_W-1:DEPTH_LOG2];
  assign wen_s            = write_enable(CS, memWrite, push);
  assign ren_s            = read_enable(CS, memRead);

  // Storage array: cleared while rst is high, written on the rising edge otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (wen_s) begin
      mem_r[idx_s] <= writeData;
    end
  end

  // Read mux: the array is only updated at the edge, so a same-cycle store shows old data
  always_comb begin
    dataOut = 16'h0000;
    if (ren_s) begin
      dataOut = mem_r[idx_s];
    end else begin
      dataOut = 16'h0000;
    end
  end

`ifdef DMEM_COLLISION_EN
  assign collision = ren_s & (memWrite | push);
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: driver queues expectations, negedge monitor checks them.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int DEPTH = 2048;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        col;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'h0;
  logic [15:0] writeData = 16'h0;
  logic [15:0] dataOut;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        CS = 1'b0;
  logic        push = 1'b0;
`ifdef DMEM_COLLISION_EN
  logic        collision;
`endif

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  logic [15:0] ref_mem [DEPTH];

  data_memory dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .dataOut(dataOut), .memRead(memRead), .memWrite(memWrite),
    .CS(CS), .push(push)
`ifdef DMEM_COLLISION_EN
    , .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  function automatic int to_idx(input logic [31:0] a);
    return int'(a % 32'd2048);
  endfunction

  // Monitor: dataOut is valid every cycle, so one pending expectation is consumed per negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (dataOut !== e.data) begin
        bad++;
        $display("FAIL %s: dataOut got %h want %h", e.name, dataOut, e.data);
      end
`ifdef DMEM_COLLISION_EN
      total++;
      if (collision !== e.col) begin
        bad++;
        $display("FAIL %s collision: got %b want %b", e.name, collision, e.col);
      end
`endif
    end
  end

  task automatic expect_now(input string name);
    exp_t e;
    logic rd_en;
    rd_en  = CS & memRead;
    e.name = name;
    e.data = (rd_en && !rst) ? ref_mem[to_idx(address)] : 16'h0000;
    e.col  = rd_en & (memWrite | push);
    exp_q.push_back(e);
  endtask

  // One access per cycle; the reference array is updated after the expectation is taken
  task automatic do_cycle(input string name, input logic cs, input logic rd,
                          input logic wr, input logic ps,
                          input logic [31:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    CS = cs; memRead = rd; memWrite = wr; push = ps; address = a; writeData = d;
    expect_now(name);
    if (cs && (wr || ps) && !rst) ref_mem[to_idx(a)] = d;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
  endtask

  initial begin
    int wait_cycles;
    clear_ref();
    // Power-on clear
    rst = 1'b1;
    #12;
    rst = 1'b0;
    do_cycle("reset_read_w5", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 16'h0);
    do_cycle("reset_read_top", 1'b1, 1'b1, 1'b0, 1'b0, STACK_TOP, 16'h0);

    do_cycle("store_5", 1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 16'hBEEF);
    do_cycle("load_5", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 16'h0);
    do_cycle("push_top", 1'b1, 1'b0, 1'b0, 1'b1, STACK_TOP, 16'h1234);
    do_cycle("pop_top", 1'b1, 1'b1, 1'b0, 1'b0, STACK_TOP, 16'h0);
    do_cycle("wrap_read_w0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
    do_cycle("alias_top", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_07FF, 16'h0);
    do_cycle("push_and_store", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 16'h5A5A);
    do_cycle("read_w0_after", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);

    do_cycle("store_7", 1'b1, 1'b0, 1'b1, 1'b0, 32'h7, 16'h0001);
    do_cycle("rbw_old", 1'b1, 1'b1, 1'b1, 1'b0, 32'h7, 16'h00FF);
    do_cycle("rbw_new", 1'b1, 1'b1, 1'b0, 1'b0, 32'h7, 16'h0);

    do_cycle("cs0_write", 1'b0, 1'b1, 1'b1, 1'b1, 32'h5, 16'hAAAA);
    do_cycle("cs0_unchanged", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 16'h0);
    do_cycle("rd0_zero", 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 16'h0);
    do_cycle("push_pop_col", 1'b1, 1'b1, 1'b0, 1'b1, 32'h9, 16'h4321);
    do_cycle("pop_9", 1'b1, 1'b1, 1'b0, 1'b0, 32'h9, 16'h0);

    // Asynchronous reset asserted mid-cycle while a read is active
    @(posedge clk);
    #1;
    CS = 1'b1; memRead = 1'b1; memWrite = 1'b0; push = 1'b0; address = 32'h5;
    #2;
    rst = 1'b1;
    clear_ref();
    expect_now("async_reset_read");
    do_cycle("write_in_reset", 1'b1, 1'b1, 1'b1, 1'b0, 32'h5, 16'h7777);
    do_cycle("still_reset", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    CS = 1'b1; memRead = 1'b1; memWrite = 1'b1; push = 1'b0;
    address = 32'h5; writeData = 16'hC0DE;
    expect_now("release_write");
    ref_mem[5] = 16'hC0DE;
    do_cycle("after_release", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 16'h0);
    do_cycle("top_cleared", 1'b1, 1'b1, 1'b0, 1'b0, STACK_TOP, 16'h0);

    // Random traffic over a small index window with random upper address bits
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] lo;
      lo = ($urandom_range(0, 3) == 0) ? (32'd2047 - 32'($urandom_range(0, 7)))
                                       : 32'($urandom_range(0, 15));
      a  = ($urandom & 32'hFFFF_F800) | lo;
      do_cycle("random", ($urandom_range(0, 7) != 0), 1'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0), a, 16'($urandom));
    end
    do_cycle("idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
